// File: rtl/playbus_pkg.sv
// rtl/playbus_pkg.sv - shared constants and seven-segment glyph table
package playbus_pkg;

  localparam int unsigned BUS_WIDTH = 4;

  localparam logic [BUS_WIDTH-1:0] ROM_VALUE = 4'h5;

  // Active-high segments, bit6..bit0 = g,f,e,d,c,b,a; entry 15 listed first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/playbus_0_if.sv
// rtl/playbus_0_if.sv - bus enables, strobes and display outputs
interface playbus_0_if;
  import playbus_pkg::*;

  logic [BUS_WIDTH-1:0] sw0;
  logic                 SWBEN;
  logic                 RAMO;
  logic                 ROMO;
  logic                 RAMW;
  logic                 LEDLTCH;
  logic [6:0]           disp0;
  logic [6:0]           disp1;

  modport master (
    output sw0, SWBEN, RAMO, ROMO, RAMW, LEDLTCH,
    input  disp0, disp1
  );

  modport slave (
    input  sw0, SWBEN, RAMO, ROMO, RAMW, LEDLTCH,
    output disp0, disp1
  );

endinterface

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex digit to seven-segment decoder
module hex_to_7seg
  import playbus_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[value];

endmodule

// File: rtl/playbus_0.sv
// rtl/playbus_0.sv - 4-bit shared bus with switch, RAM, ROM, LED latch and displays
module playbus_0
  import playbus_pkg::*;
(
  input logic         n_clk,
  input logic         reset,
  playbus_0_if.slave  pb
);

  logic [BUS_WIDTH-1:0] data_bus;
  logic [BUS_WIDTH-1:0] ram_word;
  logic [BUS_WIDTH-1:0] led_latch;

  // Resolve the bus: switches win over RAM, RAM over ROM, idle bus reads zero
  always_comb begin
    data_bus = '0;
    if (pb.SWBEN)
      data_bus = pb.sw0;
    else if (pb.RAMO)
      data_bus = ram_word;
    else if (pb.ROMO)
      data_bus = ROM_VALUE;
  end

  // RAM and LED latch sample the pre-edge bus on the falling clock edge
  always_ff @(negedge n_clk) begin
    if (reset) begin
      ram_word  <= '0;
      led_latch <= '0;
    end else begin
      if (pb.RAMW)
        ram_word <= data_bus;
      if (pb.LEDLTCH)
        led_latch <= data_bus;
    end
  end

  hex_to_7seg u_seg_latch (
    .value (led_latch),
    .seg   (pb.disp0)
  );

  hex_to_7seg u_seg_bus (
    .value (data_bus),
    .seg   (pb.disp1)
  );

endmodule

// File: tb/tb_playbus_0.sv
// tb/tb_playbus_0.sv - directed self-checking bench for playbus_0
module tb_playbus_0;

  logic n_clk;
  logic reset;
  int   n_pass;
  int   n_total;

  playbus_0_if pb ();

  playbus_0 dut (
    .n_clk (n_clk),
    .reset (reset),
    .pb    (pb.slave)
  );

  initial n_clk = 1'b1;
  always #5 n_clk = ~n_clk;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic fall_tick();
    @(negedge n_clk);
    #1;
  endtask

  task automatic idle_inputs();
    pb.sw0 = 4'h0;
    pb.SWBEN = 1'b0;
    pb.RAMO = 1'b0;
    pb.ROMO = 1'b0;
    pb.RAMW = 1'b0;
    pb.LEDLTCH = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    idle_inputs();
    fall_tick();
    reset = 1'b0;
    #1;
    check("reset_disp0", pb.disp0, 7'h3F);
    check("reset_disp1", pb.disp1, 7'h3F);

    // Switch value A onto bus and latch it
    pb.sw0 = 4'hA; pb.SWBEN = 1'b1; pb.LEDLTCH = 1'b1;
    #1;
    check("swA_disp1_live", pb.disp1, 7'h77);
    check("swA_disp0_before_edge", pb.disp0, 7'h3F);
    fall_tick();
    check("swA_disp0_latched", pb.disp0, 7'h77);
    idle_inputs();

    // Write 3 into RAM, read it back, latch it
    pb.sw0 = 4'h3; pb.SWBEN = 1'b1; pb.RAMW = 1'b1;
    fall_tick();
    idle_inputs();
    pb.RAMO = 1'b1;
    #1;
    check("ram3_disp1", pb.disp1, 7'h4F);
    check("ram3_disp0_hold", pb.disp0, 7'h77);
    pb.LEDLTCH = 1'b1;
    fall_tick();
    check("ram3_disp0_latched", pb.disp0, 7'h4F);
    idle_inputs();

    // Priority: ROM alone, switch over all, RAM over ROM
    pb.ROMO = 1'b1;
    #1;
    check("rom_disp1", pb.disp1, 7'h6D);
    pb.SWBEN = 1'b1; pb.sw0 = 4'hE;
    #1;
    check("sw_over_rom", pb.disp1, 7'h79);
    pb.RAMO = 1'b1;
    #1;
    check("sw_over_ram_rom", pb.disp1, 7'h79);
    pb.SWBEN = 1'b0;
    #1;
    check("ram_over_rom", pb.disp1, 7'h4F);
    idle_inputs();
    #1;
    check("idle_bus_zero", pb.disp1, 7'h3F);

    // RAMW and LEDLTCH together capture the same bus value
    pb.sw0 = 4'h9; pb.SWBEN = 1'b1; pb.RAMW = 1'b1; pb.LEDLTCH = 1'b1;
    fall_tick();
    idle_inputs();
    pb.RAMO = 1'b1;
    #1;
    check("dual_ram", pb.disp1, 7'h6F);
    check("dual_latch", pb.disp0, 7'h6F);

    // RAMO with RAMW rewrites the RAM word unchanged
    pb.RAMW = 1'b1;
    fall_tick();
    pb.RAMW = 1'b0;
    #1;
    check("ram_self_rewrite", pb.disp1, 7'h6F);
    idle_inputs();

    // Rising edge must not load the latch
    pb.sw0 = 4'h1; pb.SWBEN = 1'b1; pb.LEDLTCH = 1'b1;
    @(posedge n_clk);
    #1;
    check("rise_no_load", pb.disp0, 7'h6F);
    fall_tick();
    check("fall_loads", pb.disp0, 7'h06);

    // Reset overrides strobes; bus display stays live during reset
    pb.sw0 = 4'h7; pb.RAMW = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_bus_live", pb.disp1, 7'h07);
    fall_tick();
    check("reset_over_latch", pb.disp0, 7'h3F);
    reset = 1'b0;
    idle_inputs();
    pb.RAMO = 1'b1;
    #1;
    check("reset_clears_ram", pb.disp1, 7'h3F);
    idle_inputs();

    // Full glyph table through the live bus
    pb.SWBEN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pb.sw0 = 4'(i);
      #1;
      check($sformatf("glyph_%0h", i), pb.disp1, glyph[i]);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/playbus_0.md
PLAYBUS_0 -- requirements
Module: playbus_0

Interface
REQ-001 The block SHALL use one clock, n_clk; reset is synchronous and active-high, named reset; all registers update on the falling edge of n_clk.
REQ-002 n_clk  input  1  clock; state changes only on the 1->0 transition.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the n_clk falling edge.
REQ-004 sw0  input  4  switch value; drives the bus when SWBEN=1.
REQ-005 SWBEN  input  1  switch buffer enable onto the bus.
REQ-006 RAMO  input  1  RAM output enable onto the bus.
REQ-007 ROMO  input  1  ROM output enable onto the bus.
REQ-008 RAMW  input  1  RAM write strobe; captures the bus on the n_clk falling edge.
REQ-009 LEDLTCH  input  1  LED latch strobe; captures the bus on the n_clk falling edge.
REQ-010 disp0  output  7  seven-segment pattern of the LED latch contents.
REQ-011 disp1  output  7  seven-segment pattern of the live bus value.

Function
REQ-012 The internal data bus SHALL be 4 bits, resolved combinationally with priority SWBEN > RAMO > ROMO (sw0, RAM word, ROM constant); with no enable active, the bus is 4'h0.
REQ-013 The RAM SHALL be one 4-bit register; when RAMW=1 at a falling edge of n_clk it loads the bus value, otherwise it holds.
REQ-014 The ROM SHALL be the constant ROM_VALUE = 4'h5.
REQ-015 The LED latch SHALL be a 4-bit register; when LEDLTCH=1 at a falling edge it loads the bus value, otherwise it holds.
REQ-016 RAMW and LEDLTCH active together SHALL both load the same pre-edge bus value; RAMO=1 with RAMW=1 re-writes the current RAM word unchanged.
REQ-017 disp1 SHALL follow bus changes combinationally, with zero latency.
REQ-018 disp0 SHALL change only after a falling edge that loads the latch, or after reset.
REQ-019 Segment encoding SHALL be active-high, bit6..bit0 = g,f,e,d,c,b,a.
REQ-020 Hex glyph values: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 Rising edges of n_clk SHALL have no effect on state.

Reset
REQ-022 When reset=1 at a falling edge of n_clk, the RAM and the LED latch SHALL clear to 4'h0, overriding RAMW and LEDLTCH.
REQ-023 After reset, disp0 SHALL be 7'h3F; disp1 SHALL still reflect the live bus.
REQ-024 Before the first reset, register contents are undefined; the bench SHALL apply reset before checking outputs.

Structure
REQ-025 A shared package playbus_pkg SHALL hold ROM_VALUE, the bus width constant (4) and the 16-entry segment table.
REQ-026 One sub-module, hex_to_7seg (4-bit in, 7-bit out, combinational), SHALL be instantiated twice, once for disp0 and once for disp1.

Verification
REQ-027 Reset with all enables 0 -> disp0=7'h3F, disp1=7'h3F.
REQ-028 sw0=4'hA, SWBEN=1, LEDLTCH=1 -> disp1=7'h77 immediately; after the n_clk falling edge, disp0=7'h77.
REQ-029 sw0=4'h3, SWBEN=1, RAMW=1, falling edge; then SWBEN=0, RAMO=1 -> disp1=7'h4F; LEDLTCH=1, falling edge -> disp0=7'h4F.
REQ-030 ROMO=1 only -> disp1=7'h6D; SWBEN=1, sw0=4'hE also active -> disp1=7'h79 (priority check).
REQ-031 LEDLTCH=1 held while n_clk rises -> disp0 unchanged until the next falling edge; reset=1 with LEDLTCH=1 -> disp0=7'h3F.
